// File: rtl/flex_data_packer.sv
// Packs variable-length (1..N lane) input beats into dense N-lane vectors; output registered, valid the cycle after the completing accept.
// Backpressure: ready_out drops while the output register is held or a frame-end residual flush is pending.
module flex_data_packer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int CHAIN_W            = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tracing,
  input  logic                             valid_in,
  output logic                             ready_out,
  input  logic                             eof_in,
  input  logic [CHAIN_W-1:0]               chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [$clog2(N):0]               lanes_out,
  output logic                             valid_out,
  input  logic                             ready_in
);

  localparam int CW = $clog2(N);
  localparam int LW = CW + 1;

  typedef enum logic {PACK, FLUSH} state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [2*N-1:0][DATA_WIDTH-1:0]   buf_q, buf_d, merged;
  logic [7:0]                       fw_q [MAX_CHAINS];
  logic [CHAIN_W-1:0]               cfg_ptr;
  logic [7:0]                       code;
  logic [LW-1:0]                    len, t_sum;
  logic                             out_free, accept;
  logic [N-1:0][DATA_WIDTH-1:0]     vec_d;
  logic [LW-1:0]                    lanes_d;
  logic                             vld_d;

  // Firmware registers are written sequentially; any foreign configId rewinds the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHAINS; i++) fw_q[i] <= '0;
      cfg_ptr <= '0;
    end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      fw_q[cfg_ptr] <= configData;
      cfg_ptr       <= (cfg_ptr == CHAIN_W'(MAX_CHAINS - 1)) ? '0 : cfg_ptr + 1'b1;
    end else begin
      cfg_ptr <= '0;
    end
  end

  always_comb begin
    code = '0;
    for (int c = 0; c < MAX_CHAINS; c++)
      if (chainId_in == CHAIN_W'(c)) code = fw_q[c];
    if (code == 8'd0 || code > 8'(N)) len = LW'(N);
    else                              len = LW'(code);
    t_sum = LW'(cnt_q) + len;
  end

  // Buffer lanes at or above cnt are kept zero, so every load is already zero-padded.
  always_comb begin
    merged = buf_q;
    for (int i = 0; i < N; i++)
      if (LW'(i) < len) merged[int'(cnt_q) + i] = vector_in[i];
  end

  assign out_free  = !valid_out || ready_in;
  assign ready_out = tracing && (state_q == PACK) && out_free;
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    vec_d   = vector_out;
    lanes_d = lanes_out;
    vld_d   = valid_out && !ready_in;
    if (state_q == FLUSH) begin
      if (out_free) begin
        vec_d   = buf_q[N-1:0];
        lanes_d = LW'(cnt_q);
        vld_d   = 1'b1;
        cnt_d   = '0;
        buf_d   = '0;
        state_d = PACK;
      end
    end else if (accept) begin
      if (t_sum >= LW'(N)) begin
        vec_d             = merged[N-1:0];
        lanes_d           = LW'(N);
        vld_d             = 1'b1;
        buf_d             = '0;
        buf_d[N-1:0]      = merged[2*N-1:N];
        cnt_d             = CW'(t_sum - LW'(N));
        if (eof_in && t_sum != LW'(N)) state_d = FLUSH;
      end else if (eof_in) begin
        vec_d   = merged[N-1:0];
        lanes_d = t_sum;
        vld_d   = 1'b1;
        cnt_d   = '0;
        buf_d   = '0;
      end else begin
        buf_d = merged;
        cnt_d = CW'(t_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PACK;
      cnt_q      <= '0;
      buf_q      <= '0;
      vector_out <= '0;
      lanes_out  <= '0;
      valid_out  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      vector_out <= vec_d;
      lanes_out  <= lanes_d;
      valid_out  <= vld_d;
    end
  end

endmodule
